// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Turns MIPS-style instruction field sets into 32-bit instruction words and
//   writes them, one after another, to consecutive word addresses through a
//   simple write master. A 4-entry FIFO decouples field acceptance from the
//   memory side, so the producer can run ahead while the slave stalls.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   start               begin a new image: load base_address, clear
//                       word_count and error (only honoured while idle)
//   base_address[31:0]  byte address of the first word (bits [1:0] dropped)
//   in_valid / in_ready field handshake (see below)
//   instruction_code[6:0], rs, rt, rd, shamt[4:0], immediate[15:0],
//   target[25:0]        instruction fields; codes 1..52 are valid
//   avm_address/_write/_writedata/_byteenable, avm_waitrequest
//                       write master; request held stable while stalled
//   busy                FIFO non-empty or a write is outstanding
//   error               sticky; an invalid code was accepted
//   word_count[15:0]    words written since the last honoured start
//
// Handshake: a field set transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready depends only on FIFO occupancy, start and reset, never
// on in_valid. On the memory side a write completes on a rising edge where
// avm_write=1 and avm_waitrequest=0; until then address and data are held.
// ---------------------------------------------------------------------------
module instr_encoder (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] base_address,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  instruction_code,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] immediate,
   input  logic [25:0] target,
   output logic [31:0] avm_address,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        error,
   output logic [15:0] word_count
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

   localparam logic [1:0] FMT_R = 2'd0;
   localparam logic [1:0] FMT_I = 2'd1;
   localparam logic [1:0] FMT_J = 2'd2;

   state_t      state_q, state_d;
   logic [31:0] fifo_mem_q [4];
   logic [31:0] fifo_mem_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic [31:0] base_q, base_d;
   logic [15:0] word_count_q, word_count_d;
   logic        error_q, error_d;
   logic        rdy_en_q, rdy_en_d;

   logic [1:0]  fmt;
   logic [5:0]  enc_op, enc_funct;
   logic [4:0]  enc_rs, enc_rt, enc_rd, enc_sh;
   logic        code_ok;
   logic [31:0] enc_word;

   logic        accept, push, pop, start_ok;

   // ------------------------------------------------------------------
   // Encoder: pick format, opcode/funct and which fields survive.
   // ------------------------------------------------------------------
   always_comb begin
      fmt       = FMT_R;
      enc_op    = 6'h00;
      enc_funct = 6'h00;
      enc_rs    = rs;
      enc_rt    = rt;
      enc_rd    = rd;
      enc_sh    = 5'd0;
      code_ok   = 1'b1;
      case (instruction_code)
         7'd1:  enc_funct = 6'h20;                                         // ADD
         7'd2:  begin fmt = FMT_I; enc_op = 6'h08; end                     // ADDI
         7'd3:  begin fmt = FMT_I; enc_op = 6'h09; end                     // ADDIU
         7'd4:  enc_funct = 6'h21;                                         // ADDU
         7'd5:  enc_funct = 6'h24;                                         // AND
         7'd6:  begin fmt = FMT_I; enc_op = 6'h0C; end                     // ANDI
         7'd7:  begin enc_funct = 6'h1A; enc_rd = 5'd0; end                // DIV
         7'd8:  begin enc_funct = 6'h1B; enc_rd = 5'd0; end                // DIVU
         7'd9:  begin enc_funct = 6'h10; enc_rs = 5'd0; enc_rt = 5'd0; end // MFHI
         7'd10: begin enc_funct = 6'h12; enc_rs = 5'd0; enc_rt = 5'd0; end // MFLO
         7'd11: begin enc_funct = 6'h11; enc_rt = 5'd0; enc_rd = 5'd0; end // MTHI
         7'd12: begin enc_funct = 6'h13; enc_rt = 5'd0; enc_rd = 5'd0; end // MTLO
         7'd13: begin enc_funct = 6'h18; enc_rd = 5'd0; end                // MULT
         7'd14: begin enc_funct = 6'h19; enc_rd = 5'd0; end                // MULTU
         7'd15: enc_funct = 6'h25;                                         // OR
         7'd16: begin fmt = FMT_I; enc_op = 6'h0D; end                     // ORI
         7'd17: begin enc_funct = 6'h00; enc_rs = 5'd0; enc_sh = shamt; end // SLL
         7'd18: enc_funct = 6'h04;                                         // SLLV
         7'd19: enc_funct = 6'h2A;                                         // SLT
         7'd20: begin fmt = FMT_I; enc_op = 6'h0A; end                     // SLTI
         7'd21: begin fmt = FMT_I; enc_op = 6'h0B; end                     // SLTIU
         7'd22: enc_funct = 6'h2B;                                         // SLTU
         7'd23: begin enc_funct = 6'h03; enc_rs = 5'd0; enc_sh = shamt; end // SRA
         7'd24: enc_funct = 6'h07;                                         // SRAV
         7'd25: begin enc_funct = 6'h02; enc_rs = 5'd0; enc_sh = shamt; end // SRL
         7'd26: enc_funct = 6'h06;                                         // SRLV
         7'd27: enc_funct = 6'h23;                                         // SUBU
         7'd28: enc_funct = 6'h26;                                         // XOR
         7'd29: begin fmt = FMT_I; enc_op = 6'h0E; end                     // XORI
         7'd30: begin fmt = FMT_I; enc_op = 6'h04; end                     // BEQ
         // REGIMM branches: the rt field selects the condition.
         7'd31: begin fmt = FMT_I; enc_op = 6'h01; enc_rt = 5'b00001; end  // BGEZ
         7'd32: begin fmt = FMT_I; enc_op = 6'h01; enc_rt = 5'b10001; end  // BGEZAL
         7'd33: begin fmt = FMT_I; enc_op = 6'h07; enc_rt = 5'd0; end      // BGTZ
         7'd34: begin fmt = FMT_I; enc_op = 6'h06; enc_rt = 5'd0; end      // BLEZ
         7'd35: begin fmt = FMT_I; enc_op = 6'h01; enc_rt = 5'b00000; end  // BLTZ
         7'd36: begin fmt = FMT_I; enc_op = 6'h01; enc_rt = 5'b10000; end  // BLTZAL
         7'd37: begin fmt = FMT_I; enc_op = 6'h05; end                     // BNE
         7'd38: begin fmt = FMT_J; enc_op = 6'h02; end                     // J
         7'd39: begin fmt = FMT_J; enc_op = 6'h03; end                     // JAL
         7'd40: begin enc_funct = 6'h09; enc_rt = 5'd0; end                // JALR
         7'd41: begin enc_funct = 6'h08; enc_rt = 5'd0; enc_rd = 5'd0; end // JR
         7'd42: begin fmt = FMT_I; enc_op = 6'h20; end                     // LB
         7'd43: begin fmt = FMT_I; enc_op = 6'h24; end                     // LBU
         7'd44: begin fmt = FMT_I; enc_op = 6'h21; end                     // LH
         7'd45: begin fmt = FMT_I; enc_op = 6'h25; end                     // LHU
         7'd46: begin fmt = FMT_I; enc_op = 6'h0F; enc_rs = 5'd0; end      // LUI
         7'd47: begin fmt = FMT_I; enc_op = 6'h23; end                     // LW
         7'd48: begin fmt = FMT_I; enc_op = 6'h22; end                     // LWL
         7'd49: begin fmt = FMT_I; enc_op = 6'h26; end                     // LWR
         7'd50: begin fmt = FMT_I; enc_op = 6'h28; end                     // SB
         7'd51: begin fmt = FMT_I; enc_op = 6'h29; end                     // SH
         7'd52: begin fmt = FMT_I; enc_op = 6'h2B; end                     // SW
         default: code_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (fmt)
         FMT_I:   enc_word = {enc_op, enc_rs, enc_rt, immediate};
         FMT_J:   enc_word = {enc_op, target};
         default: enc_word = {6'h00, enc_rs, enc_rt, enc_rd, enc_sh, enc_funct};
      endcase
   end

   // ------------------------------------------------------------------
   // Handshake and status
   // ------------------------------------------------------------------
   // rdy_en_q keeps in_ready low throughout reset and until the first edge.
   assign in_ready = rdy_en_q & (count_q < 3'd4) & ~start;
   assign busy     = (count_q != 3'd0) | (state_q == ST_WRITE);
   assign accept   = in_valid & in_ready;
   assign push     = accept & code_ok;
   assign pop      = (state_q == ST_WRITE) & ~avm_waitrequest;
   assign start_ok = start & ~busy;

   assign error      = error_q;
   assign word_count = word_count_q;

   // ------------------------------------------------------------------
   // FIFO, counters and configuration next-state
   // ------------------------------------------------------------------
   always_comb begin
      fifo_mem_d   = fifo_mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      base_d       = base_q;
      word_count_d = word_count_q;
      error_d      = error_q;
      rdy_en_d     = 1'b1;

      if (push) begin
         fifo_mem_d[wr_ptr_q] = enc_word;
         wr_ptr_d             = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d     = rd_ptr_q + 2'd1;
         word_count_d = word_count_q + 16'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase

      if (accept && !code_ok) begin
         error_d = 1'b1;
      end
      // start_ok implies an idle, empty block, so it never races a pop.
      if (start_ok) begin
         base_d       = {base_address[31:2], 2'b00};
         word_count_d = 16'd0;
         error_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            fifo_mem_q[i] <= 32'd0;
         end
         wr_ptr_q     <= 2'd0;
         rd_ptr_q     <= 2'd0;
         count_q      <= 3'd0;
         base_q       <= 32'd0;
         word_count_q <= 16'd0;
         error_q      <= 1'b0;
         rdy_en_q     <= 1'b0;
      end else begin
         fifo_mem_q   <= fifo_mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         base_q       <= base_d;
         word_count_q <= word_count_d;
         error_q      <= error_d;
         rdy_en_q     <= rdy_en_d;
      end
   end

   // ------------------------------------------------------------------
   // Write FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (count_q != 3'd0) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // count_d already accounts for a push landing on the pop edge.
            if (pop && (count_d == 3'd0)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      avm_write      = 1'b0;
      avm_address    = 32'd0;
      avm_writedata  = 32'd0;
      avm_byteenable = 4'b1111;
      if (state_q == ST_WRITE) begin
         avm_write     = 1'b1;
         avm_address   = base_q + {14'd0, word_count_q, 2'b00};
         avm_writedata = fifo_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder: directed bench for instr_encoder. The stimulus side
// queues {address, data} for every valid field set at acceptance; a monitor
// pops and compares on every completed write.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        start;
   logic [31:0] base_address;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  instruction_code;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] immediate;
   logic [25:0] target;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic        busy;
   logic        error;
   logic [15:0] word_count;

   instr_encoder dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .base_address     (base_address),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .instruction_code (instruction_code),
      .rs               (rs),
      .rt               (rt),
      .rd               (rd),
      .shamt            (shamt),
      .immediate        (immediate),
      .target           (target),
      .avm_address      (avm_address),
      .avm_write        (avm_write),
      .avm_writedata    (avm_writedata),
      .avm_byteenable   (avm_byteenable),
      .avm_waitrequest  (avm_waitrequest),
      .busy             (busy),
      .error            (error),
      .word_count       (word_count)
   );

   // ---------------- scoreboard ----------------
   int          vec_count  = 0;
   int          miss_count = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] m_base = 32'd0;
   int          m_idx  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // monitor: a write completes at the next rising edge
   always @(negedge clk) begin
      if (reset_n && avm_write && !avm_waitrequest) begin
         if (exp_q.size() == 0) begin
            vec_count++;
            miss_count++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, want no write",
                     avm_address, avm_writedata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", {32'd0, avm_address}, {32'd0, mon_e[63:32]});
            chk("wr_data", {32'd0, avm_writedata}, {32'd0, mon_e[31:0]});
            chk("wr_byteenable", {60'd0, avm_byteenable}, 64'hF);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [6:0] code, input logic [4:0] f_rs, input logic [4:0] f_rt,
                        input logic [4:0] f_rd, input logic [4:0] f_sh,
                        input logic [15:0] imm, input logic [25:0] tgt);
      in_valid         = 1'b1;
      instruction_code = code;
      rs               = f_rs;
      rt               = f_rt;
      rd               = f_rd;
      shamt            = f_sh;
      immediate        = imm;
      target           = tgt;
   endtask

   // Holds the driven field set until accepted; returns 1 time unit after
   // the acceptance edge.
   task automatic wait_accept(input logic [31:0] exp_data);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            if (instruction_code >= 7'd1 && instruction_code <= 7'd52) begin
               exp_q.push_back({m_base + 32'(m_idx * 4), exp_data});
               m_idx++;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            done = 1'b1;
         end else begin
            n++;
            if (n > 200) begin
               vec_count++;
               miss_count++;
               $display("FAIL accept_timeout: in_ready stayed 0, want 1");
               @(posedge clk);
               #1 in_valid = 1'b0;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic send(input logic [6:0] code, input logic [4:0] f_rs, input logic [4:0] f_rt,
                       input logic [4:0] f_rd, input logic [4:0] f_sh,
                       input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] exp_data);
      drive(code, f_rs, f_rt, f_rd, f_sh, imm, tgt);
      wait_accept(exp_data);
   endtask

   task automatic do_start(input logic [31:0] b);
      start        = 1'b1;
      base_address = b;
      #1 chk("in_ready_during_start", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1 start = 1'b0;
      m_base = {b[31:2], 2'b00};
      m_idx  = 0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (busy) begin
         vec_count++;
         miss_count++;
         $display("FAIL idle_timeout: busy=1, want 0");
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n          = 1'b0;
      start            = 1'b0;
      base_address     = 32'd0;
      in_valid         = 1'b0;
      instruction_code = 7'd0;
      rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0;
      immediate        = 16'd0;
      target           = 26'd0;
      avm_waitrequest  = 1'b0;

      // reset values
      #12;
      chk("rst_in_ready",   {63'd0, in_ready},  64'd0);
      chk("rst_busy",       {63'd0, busy},      64'd0);
      chk("rst_avm_write",  {63'd0, avm_write}, 64'd0);
      chk("rst_avm_addr",   {32'd0, avm_address},   64'd0);
      chk("rst_avm_data",   {32'd0, avm_writedata}, 64'd0);
      chk("rst_word_count", {48'd0, word_count}, 64'd0);
      chk("rst_error",      {63'd0, error},     64'd0);
      #5 reset_n = 1'b1;
      @(posedge clk);
      #1 chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

      // ADD and first-write latency
      do_start(32'h0000_1000);
      send(7'd1, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 32'h0022_1820);
      chk("lat_acc_edge_write", {63'd0, avm_write}, 64'd0);
      chk("lat_acc_edge_busy",  {63'd0, busy},      64'd1);
      @(posedge clk);
      #1 chk("lat_next_edge_write", {63'd0, avm_write}, 64'd1);
      chk("lat_next_edge_addr", {32'd0, avm_address}, 64'h1000);
      wait_idle();
      chk("wc_after_add", {48'd0, word_count}, 64'd1);

      // encoding table, back to back
      send(7'd17, 5'd9,  5'd2,  5'd3, 5'd4, 16'h0,    26'h0,       32'h0002_1900); // SLL
      send(7'd32, 5'd4,  5'd7,  5'd0, 5'd0, 16'hFFFE, 26'h0,       32'h0491_FFFE); // BGEZAL
      send(7'd39, 5'd0,  5'd0,  5'd0, 5'd0, 16'h0,    26'h0100010, 32'h0C10_0010); // JAL
      send(7'd2,  5'd3,  5'd4,  5'd9, 5'd9, 16'h1234, 26'h0,       32'h2064_1234); // ADDI
      send(7'd13, 5'd5,  5'd6,  5'd7, 5'd1, 16'h0,    26'h0,       32'h00A6_0018); // MULT
      send(7'd46, 5'd7,  5'd8,  5'd0, 5'd0, 16'hABCD, 26'h0,       32'h3C08_ABCD); // LUI
      send(7'd41, 5'd31, 5'd5,  5'd5, 5'd5, 16'h0,    26'h0,       32'h03E0_0008); // JR
      send(7'd34, 5'd2,  5'd3,  5'd0, 5'd0, 16'h0010, 26'h0,       32'h1840_0010); // BLEZ
      send(7'd52, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0,       32'hAFBF_0004); // SW
      wait_idle();
      chk("wc_after_table", {48'd0, word_count}, 64'd10);

      // backpressure: FIFO fills to 4, fifth offer waits
      do_start(32'h0000_2003);
      avm_waitrequest = 1'b1;
      send(7'd15, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0,    26'h0, 32'h0022_1825); // OR
      send(7'd28, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0,    26'h0, 32'h0085_3026); // XOR
      send(7'd27, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0,    26'h0, 32'h0021_0823); // SUBU
      send(7'd16, 5'd2, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h3443_FFFF); // ORI
      drive(7'd30, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0008, 26'h0);               // BEQ
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {63'd0, in_ready},  64'd0);
         chk("bp_write",    {63'd0, avm_write}, 64'd1);
         chk("bp_addr",     {32'd0, avm_address},   64'h2000);
         chk("bp_data",     {32'd0, avm_writedata}, 64'h0022_1825);
      end
      @(posedge clk);
      #1 avm_waitrequest = 1'b0;
      wait_accept(32'h1022_0008);
      wait_idle();
      chk("wc_after_bp", {48'd0, word_count}, 64'd5);

      // invalid codes
      do_start(32'h0000_3000);
      send(7'd47, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h8C64_0010); // LW
      wait_idle();
      chk("wc_before_invalid", {48'd0, word_count}, 64'd1);
      send(7'd0, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h0);
      chk("err_code0", {63'd0, error}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_write_code0", {63'd0, avm_write}, 64'd0);
      end
      chk("wc_after_code0", {48'd0, word_count}, 64'd1);
      @(posedge clk);
      #1 do_start(32'h0000_3100);
      chk("err_cleared_1", {63'd0, error}, 64'd0);
      chk("wc_cleared",    {48'd0, word_count}, 64'd0);
      send(7'd53, 5'd2, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 32'h0);
      chk("err_code53", {63'd0, error}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_write_code53", {63'd0, avm_write}, 64'd0);
      end
      chk("wc_after_code53", {48'd0, word_count}, 64'd0);
      chk("busy_after_code53", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1 do_start(32'h0000_3200);
      chk("err_cleared_2", {63'd0, error}, 64'd0);

      // start while busy is ignored
      avm_waitrequest = 1'b1;
      send(7'd19, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_182A); // SLT
      @(posedge clk);
      #1 chk("busy_before_start", {63'd0, busy}, 64'd1);
      start        = 1'b1;
      base_address = 32'h0000_9000;
      #1 chk("in_ready_busy_start", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1 start = 1'b0;
      avm_waitrequest = 1'b0;
      send(7'd22, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_182B); // SLTU
      wait_idle();
      chk("wc_after_busy_start", {48'd0, word_count}, 64'd2);

      // reset mid-write
      avm_waitrequest = 1'b1;
      send(7'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1824); // AND
      @(posedge clk);
      #1 chk("mid_write_active", {63'd0, avm_write}, 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rstmid_write",    {63'd0, avm_write}, 64'd0);
      chk("rstmid_busy",     {63'd0, busy},      64'd0);
      chk("rstmid_in_ready", {63'd0, in_ready},  64'd0);
      chk("rstmid_addr",     {32'd0, avm_address}, 64'd0);
      chk("rstmid_wc",       {48'd0, word_count},  64'd0);
      exp_q.delete();
      m_base = 32'd0;
      m_idx  = 0;
      @(posedge clk);
      #1 avm_waitrequest = 1'b0;
      #2 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_retry_write", {63'd0, avm_write}, 64'd0);
      end
      chk("post_rst_busy",     {63'd0, busy},       64'd0);
      chk("post_rst_wc",       {48'd0, word_count}, 64'd0);
      chk("post_rst_error",    {63'd0, error},      64'd0);
      chk("post_rst_in_ready", {63'd0, in_ready},   64'd1);

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have exactly one clock and one reset, with the following ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-002 The block SHALL have the following command ports:
- start  in  1  begin new program image; loads base_address.
- base_address  in  32  byte address of the first encoded word.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block accepts fields this cycle.
- instruction_code  in  7  operation code, numbering per REQ-007.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- immediate  in  16  I-type immediate or branch offset.
- target  in  26  J-type word target.
REQ-003 The block SHALL have the following memory write-master ports:
- avm_address  out  32  word-aligned write address.
- avm_write  out  1  write request.
- avm_writedata  out  32  encoded instruction word.
- avm_byteenable  out  4  constant 4'b1111.
- avm_waitrequest  in  1  slave stall.
REQ-004 The block SHALL have the following status ports:
- busy  out  1  FIFO non-empty or write in progress.
- error  out  1  sticky; an invalid code was seen.
- word_count  out  16  words written since last start.

Function
REQ-005 Transfer rules:
- A field set is accepted on a rising edge with in_valid=1 and in_ready=1.
- in_ready = (FIFO count < 4) and not start.
REQ-006 Accepted valid codes SHALL be encoded combinationally and pushed into a 4-entry FIFO in the same edge.
REQ-007 Codes 1..52 SHALL map, in order, to: ADD ADDI ADDIU ADDU AND ANDI DIV DIVU MFHI MFLO MTHI MTLO MULT MULTU OR ORI SLL SLLV SLT SLTI SLTIU SLTU SRA SRAV SRL SRLV SUBU XOR XORI BEQ BGEZ BGEZAL BGTZ BLEZ BLTZ BLTZAL BNE J JAL JALR JR LB LBU LH LHU LUI LW LWL LWR SB SH SW.
REQ-008 R-type words SHALL use opcode 0 with the following funct values (hex):
- ADD 20, ADDU 21, AND 24, DIV 1A, DIVU 1B
- MFHI 10, MFLO 12, MTHI 11, MTLO 13, MULT 18, MULTU 19
- OR 25, SLL 00, SLLV 04, SLT 2A, SLTU 2B, SRA 03, SRAV 07
- SRL 02, SRLV 06, SUBU 23, XOR 26, JALR 09, JR 08
REQ-009 I-type and J-type words SHALL use the following opcodes (hex):
- ADDI 08, ADDIU 09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F
- BEQ 04, BNE 05, BLEZ 06, BGTZ 07
- LB 20, LH 21, LWL 22, LW 23, LBU 24, LHU 25, LWR 26, SB 28, SH 29, SW 2B
- J 02, JAL 03
REQ-010 BGEZ, BGEZAL, BLTZ and BLTZAL SHALL use opcode 01, with the rt field forced to 00001, 10001, 00000 and 10000 respectively; the rt input is ignored.
REQ-011 Unused fields SHALL be forced to zero:
- shamt zero unless SLL/SRA/SRL.
- rs zero for SLL/SRA/SRL/LUI/MFHI/MFLO.
- rt zero for MFHI/MFLO/MTHI/MTLO/JR/JALR/BGTZ/BLEZ.
- rd zero for MULT/MULTU/DIV/DIVU/MTHI/MTLO/JR.
REQ-012 J and JAL words SHALL be {opcode, target}.
REQ-013 An accepted code of 0 or >52 SHALL be consumed without a push and SHALL set error.
REQ-014 The write FSM SHALL have states IDLE and WRITE:
- IDLE -> WRITE on the edge where the FIFO is non-empty.
- avm_write=1 exactly while in WRITE.
REQ-015 In WRITE, the FSM SHALL behave as follows:
- avm_writedata = FIFO head.
- avm_address = base + 4*word_count.
- Both held stable while avm_waitrequest=1.
REQ-016 On an edge in WRITE with avm_waitrequest=0, the block SHALL:
- pop the FIFO;
- increment word_count, wrapping 0xFFFF -> 0;
- stay in WRITE if the FIFO still holds data, otherwise go to IDLE.
REQ-017 Latency: a push into an empty idle block SHALL produce avm_write=1 in the cycle following the next edge (acceptance edge +1).
REQ-018 Simultaneous push and pop SHALL be legal, with the count unchanged.
REQ-019 start SHALL be honoured only when busy=0; then it:
- loads base with bits[1:0] forced to 0;
- clears word_count and error.
REQ-020 start while busy=1 SHALL be ignored, but in_ready SHALL still be held 0.
REQ-021 Address arithmetic SHALL wrap modulo 2^32.
REQ-022 busy SHALL equal (FIFO count != 0) or (state == WRITE).

Reset
REQ-023 reset_n=0 SHALL immediately, without waiting for a clock edge:
- force IDLE;
- empty the FIFO;
- set avm_write=0 and avm_address, avm_writedata, word_count, base and error to 0;
- set busy=0 and in_ready=0.
REQ-024 After reset_n is released, in_ready SHALL be 1 from the first edge onward (since start=0).
REQ-025 A reset asserted mid-write SHALL abandon the transfer; no retry SHALL occur after release.

Verification
REQ-026 The bench SHALL cover the following scenarios:
- Encoding: start base=0x1000, then ADD (1) rs=1 rt=2 rd=3 shamt=5 -> one write, address 0x1000, data 0x00221820, word_count=1.
- Encoding: SLL (17) rs=9 rt=2 rd=3 shamt=4 -> 0x00021900; BGEZAL (32) rs=4 rt=7 imm=0xFFFE -> 0x0491FFFE; JAL (39) target=0x0100010 -> 0x0C100010.
- Backpressure: avm_waitrequest=1 while 5 codes are offered -> in_ready=0 after 4 are accepted, address and data stable; on release, addresses are base, +4, +8, +12, +16 with word_count=5.
- Invalid codes: 0 and 53 -> error=1, no avm_write, word_count unchanged; a following start clears error.
- Start while busy: start asserted while busy=1 -> ignored, base unchanged, in_ready=0 during start.
- Reset mid-write: reset_n low while avm_write=1 and avm_waitrequest=1 -> avm_write=0 immediately; after release busy=0 and word_count=0.
